// File: rtl/game_pkg.sv
// Shared definitions for the vanishing-mark tic-tac-toe datapath:
// cell codes, display game_state codes, sequencer FSM states and win lines.
package game_pkg;

    localparam logic [1:0] CELL_EMPTY = 2'b00;
    localparam logic [1:0] CELL_O     = 2'b01;
    localparam logic [1:0] CELL_X     = 2'b10;

    localparam logic [1:0] GS_IDLE = 2'b00;
    localparam logic [1:0] GS_PLAY = 2'b01;
    localparam logic [1:0] GS_BUSY = 2'b10;
    localparam logic [1:0] GS_OVER = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_PLAY,
        ST_COMMIT,
        ST_SETTLE,
        ST_CHECK,
        ST_OVER
    } fsm_state_t;

    localparam int unsigned NUM_LINES = 8;

    // Rows, columns, then the two diagonals; cells numbered row-major 0..8.
    localparam logic [3:0] WIN_LINES [NUM_LINES][3] = '{
        '{4'd0, 4'd1, 4'd2},
        '{4'd3, 4'd4, 4'd5},
        '{4'd6, 4'd7, 4'd8},
        '{4'd0, 4'd3, 4'd6},
        '{4'd1, 4'd4, 4'd7},
        '{4'd2, 4'd5, 4'd8},
        '{4'd0, 4'd4, 4'd8},
        '{4'd2, 4'd4, 4'd6}
    };

    function automatic logic [1:0] state_to_gs(input fsm_state_t s);
        logic [1:0] gs;
        case (s)
            ST_IDLE: gs = GS_IDLE;
            ST_PLAY: gs = GS_PLAY;
            ST_OVER: gs = GS_OVER;
            default: gs = GS_BUSY;
        endcase
        return gs;
    endfunction

endpackage

// File: rtl/turn_sequencer_line_checker.sv
// line_checker: combinational three-in-a-row detector for one player code.
// Shared between the turn sequencer and the display highlight logic.
module line_checker
    import game_pkg::*;
(
    input  logic [17:0] grid,
    input  logic [1:0]  player,
    output logic        win
);

    function automatic logic [1:0] cell_of(input logic [17:0] g, input logic [3:0] idx);
        return g[{idx, 1'b0} +: 2];
    endfunction

    always_comb begin
        win = 1'b0;
        for (int unsigned i = 0; i < NUM_LINES; i++) begin
            if (player != CELL_EMPTY &&
                cell_of(grid, WIN_LINES[i][0]) == player &&
                cell_of(grid, WIN_LINES[i][1]) == player &&
                cell_of(grid, WIN_LINES[i][2]) == player)
                win = 1'b1;
        end
    end

endmodule

// File: rtl/turn_sequencer.sv
// turn_sequencer: game-flow controller that validates moves, issues mark commands
// and decides turn hand-over or game end. Optional per-turn timer: TURN_TIMEOUT_EN.
module turn_sequencer
    import game_pkg::*;
#(
    parameter logic        FIRST_PLAYER   = 1'b1,
    parameter int unsigned SETTLE_CYCLES  = 1,
    parameter int unsigned TIMEOUT_CYCLES = 500000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        move_valid,
    input  logic [3:0]  move_pos,
    input  logic [17:0] grid,
    output logic [1:0]  game_state,
    output logic        whos_turn,
    output logic [1:0]  mark,
    output logic [3:0]  position,
    output logic        board_clr_n,
    output logic        move_ack,
    output logic        move_reject,
    output logic [1:0]  winner,
    output logic [7:0]  move_count
);

    fsm_state_t state, state_d;

    logic [1:0]  settle_cnt, settle_d;
    logic        whos_d, clr_d, ack_d, rej_d;
    logic [1:0]  mark_d, winner_d;
    logic [3:0]  pos_d;
    logic [7:0]  cnt_d;

    logic [1:0]  mover;
    logic        mover_wins;
    logic [31:0] grid_ext;
    logic        move_ok;
    logic        turn_expired;

    line_checker u_line_checker (
        .grid   (grid),
        .player (mover),
        .win    (mover_wins)
    );

    assign mover    = whos_turn ? CELL_X : CELL_O;
    // Zero-extended so an out-of-range move_pos never indexes past the board.
    assign grid_ext = {14'd0, grid};
    assign move_ok  = (move_pos <= 4'd8) && (grid_ext[{move_pos, 1'b0} +: 2] == CELL_EMPTY);

`ifdef TURN_TIMEOUT_EN
    logic [31:0] turn_timer;

    assign turn_expired = (state == ST_PLAY) && (turn_timer == TIMEOUT_CYCLES - 1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            turn_timer <= '0;
        else if (state != ST_PLAY || turn_expired)
            turn_timer <= '0;
        else
            turn_timer <= turn_timer + 32'd1;
    end
`else
    assign turn_expired = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= ST_IDLE;
        else
            state <= state_d;
    end

    always_comb begin
        state_d  = state;
        settle_d = settle_cnt;
        whos_d   = whos_turn;
        mark_d   = CELL_EMPTY;
        pos_d    = position;
        clr_d    = 1'b1;
        ack_d    = 1'b0;
        rej_d    = 1'b0;
        winner_d = winner;
        cnt_d    = move_count;

        case (state)
            ST_IDLE, ST_OVER: begin
                if (start) begin
                    state_d  = ST_CLEAR;
                    clr_d    = 1'b0;
                    winner_d = CELL_EMPTY;
                    cnt_d    = '0;
                    whos_d   = FIRST_PLAYER;
                end
            end
            ST_CLEAR: state_d = ST_PLAY;
            ST_PLAY: begin
                // An accepted move outranks a timer expiry in the same cycle.
                if (move_valid && move_ok) begin
                    state_d = ST_COMMIT;
                    ack_d   = 1'b1;
                    mark_d  = mover;
                    pos_d   = move_pos;
                    cnt_d   = (move_count == 8'hFF) ? move_count : move_count + 8'd1;
                end else begin
                    rej_d = move_valid;
                    if (turn_expired)
                        whos_d = ~whos_turn;
                end
            end
            ST_COMMIT: begin
                state_d  = ST_SETTLE;
                settle_d = '0;
            end
            ST_SETTLE: begin
                if (settle_cnt == 2'(SETTLE_CYCLES - 1))
                    state_d = ST_CHECK;
                else
                    settle_d = settle_cnt + 2'd1;
            end
            ST_CHECK: begin
                if (mover_wins) begin
                    state_d  = ST_OVER;
                    winner_d = mover;
                end else begin
                    state_d = ST_PLAY;
                    whos_d  = ~whos_turn;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            settle_cnt  <= '0;
            game_state  <= GS_IDLE;
            whos_turn   <= FIRST_PLAYER;
            mark        <= CELL_EMPTY;
            position    <= '0;
            board_clr_n <= 1'b1;
            move_ack    <= 1'b0;
            move_reject <= 1'b0;
            winner      <= CELL_EMPTY;
            move_count  <= '0;
        end else begin
            settle_cnt  <= settle_d;
            game_state  <= state_to_gs(state_d);
            whos_turn   <= whos_d;
            mark        <= mark_d;
            position    <= pos_d;
            board_clr_n <= clr_d;
            move_ack    <= ack_d;
            move_reject <= rej_d;
            winner      <= winner_d;
            move_count  <= cnt_d;
        end
    end

endmodule
